// File: rtl/divi_pkg.sv
// rtl/divi_pkg.sv - shared widths, FSM state type and divide-by-zero result constants for divi_core
//
// Purpose : common definitions imported by divi_step and divi_core.
// Contents: DIVI_DIVIDEND_W / DIVI_DIVISOR_W operand widths, iteration counter width,
//           divi_state_e (IDLE, BUSY), and the fixed results reported for a zero divisor.
package divi_pkg;

    localparam int DIVI_DIVIDEND_W = 25;
    localparam int DIVI_DIVISOR_W  = 16;
    localparam int DIVI_CNT_W      = $clog2(DIVI_DIVIDEND_W);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } divi_state_e;

    // Results forced on a zero divisor so they do not depend on the dividend.
    localparam logic [DIVI_DIVIDEND_W-1:0] DIVI_DIV0_QUOT = '1;
    localparam logic [DIVI_DIVISOR_W-1:0]  DIVI_DIV0_FRAC = '0;

endpackage

// File: rtl/divi_step.sv
// rtl/divi_step.sv - one combinational radix-2 restoring division step
//
// Purpose : shifts the next dividend bit into the partial remainder and subtracts the
//           divisor when it fits, yielding one quotient bit.
// Ports   : rem_in   [DIVISOR_W:0]   partial remainder before the step
//           bit_in                   next dividend bit (MSB first)
//           divisor  [DIVISOR_W-1:0] divisor
//           rem_out  [DIVISOR_W:0]   partial remainder after the step
//           q_bit                    quotient bit produced by this step
module divi_step
    import divi_pkg::*;
#(
    parameter int DIVISOR_W = DIVI_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] rem_shift;
    logic [DIVISOR_W:0]   rem_diff;

    always_comb begin
        rem_shift = {rem_in, bit_in};
        q_bit     = (rem_shift >= {2'b00, divisor});
        // When the divisor fits, the difference is below 2**(DIVISOR_W+1), so the
        // subtraction can be done on the low DIVISOR_W+1 bits alone.
        rem_diff  = rem_shift[DIVISOR_W:0] - {1'b0, divisor};
        rem_out   = q_bit ? rem_diff : rem_shift[DIVISOR_W:0];
    end

endmodule

// File: rtl/divi_core.sv
// rtl/divi_core.sv - iterative unsigned 25/16 restoring divider, one quotient bit per clock
//
// Purpose : samples dividend/divisor on every edge while idle, then spends DIVIDEND_W
//           edges in BUSY producing quotient and remainder (fractional), MSB first.
// Ports   : sys_clk     system clock, rising edge
//           sys_rst     synchronous active-high reset
//           dividend    [DIVIDEND_W-1:0] unsigned dividend, sampled only while rfd=1
//           divisor     [DIVISOR_W-1:0]  unsigned divisor, sampled only while rfd=1
//           quotient    [DIVIDEND_W-1:0] registered quotient of last completed division
//           fractional  [DIVISOR_W-1:0]  registered remainder of last completed division
//           rfd         ready-for-data, high while idle
//           div_by_zero (only with DIVI_DIV0_FLAG_EN) set when the finished division had divisor 0
// Options : define DIVI_DIV0_FLAG_EN to add the div_by_zero output.
module divi_core
    import divi_pkg::*;
#(
    parameter int DIVIDEND_W = DIVI_DIVIDEND_W,
    parameter int DIVISOR_W  = DIVI_DIVISOR_W
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  fractional,
`ifdef DIVI_DIV0_FLAG_EN
    output logic                  div_by_zero,
`endif
    output logic                  rfd
);

    localparam int              CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    divi_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;      // dividend, shifted left once per step
    logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
    logic [DIVISOR_W:0]      rem_q, rem_d;      // one extra bit so divisor=all-ones cannot overflow
    logic [DIVIDEND_W-1:0]   quo_q, quo_d;
    logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]    fractional_q, fractional_d;
    logic                    rfd_q, rfd_d;
    logic                    dbz_q, dbz_d;

    logic [DIVISOR_W:0]      step_rem;
    logic                    step_bit;

    divi_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        quotient_d   = quotient_q;
        fractional_d = fractional_q;
        rfd_d        = rfd_q;
        dbz_d        = dbz_q;

        case (state_q)
            IDLE: begin
                dvd_d   = dividend;
                dvs_d   = divisor;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = CNT_LAST;
                state_d = BUSY;
                rfd_d   = 1'b0;
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = {quo_q[DIVIDEND_W-2:0], step_bit};
                dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    rfd_d   = 1'b1;
                    // A zero divisor makes every step "fit", so the natural quotient is
                    // already all ones, but the remainder would echo dividend bits; both
                    // are forced so the result is well defined.
                    if (dvs_q == '0) begin
                        quotient_d   = DIVI_DIV0_QUOT;
                        fractional_d = DIVI_DIV0_FRAC;
                        dbz_d        = 1'b1;
                    end else begin
                        quotient_d   = {quo_q[DIVIDEND_W-2:0], step_bit};
                        fractional_d = step_rem[DIVISOR_W-1:0];
                        dbz_d        = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rfd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            quotient_q   <= '0;
            fractional_q <= '0;
            rfd_q        <= 1'b1;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            quotient_q   <= quotient_d;
            fractional_q <= fractional_d;
            rfd_q        <= rfd_d;
            dbz_q        <= dbz_d;
        end
    end

    assign quotient   = quotient_q;
    assign fractional = fractional_q;
    assign rfd        = rfd_q;

`ifdef DIVI_DIV0_FLAG_EN
    assign div_by_zero = dbz_q;
`else
    logic unused_dbz;
    assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_divi_core.sv
// tb/tb_divi_core.sv - table-driven self-checking bench for divi_core
module tb_divi_core;

    logic        sys_clk;
    logic        sys_rst;
    logic [24:0] dividend;
    logic [15:0] divisor;
    logic [24:0] quotient;
    logic [15:0] fractional;
    logic        rfd;
`ifdef DIVI_DIV0_FLAG_EN
    logic        div_by_zero;
`endif

    int checks   = 0;
    int failures = 0;

    divi_core dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .fractional  (fractional),
`ifdef DIVI_DIV0_FLAG_EN
        .div_by_zero (div_by_zero),
`endif
        .rfd         (rfd)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [24:0] dd;
        logic [15:0] dv;
        logic [24:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps edge by edge (sampling 1 time unit after each) until rfd is seen high.
    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!rfd && n < 40);
        if (!rfd) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got rfd=0 after %0d edges expected rfd=1", name, n);
        end
    endtask

    // Called 1 time unit after an edge with rfd=1: the next edge captures the operands.
    task automatic do_div(input string name, input logic [24:0] dd, input logic [15:0] dv,
                          input logic [24:0] eq, input logic [15:0] er, input logic ez);
        int n;
        dividend = dd;
        divisor  = dv;
        @(posedge sys_clk);
        #1;
        chk({name, "_rfd_fall"}, 32'(rfd), 32'd0);
        wait_done(name, n);
        chk({name, "_latency"}, 32'(n + 1), 32'd26);
        chk({name, "_quot"}, 32'(quotient), 32'(eq));
        chk({name, "_frac"}, 32'(fractional), 32'(er));
`ifdef DIVI_DIV0_FLAG_EN
        chk({name, "_dbz"}, 32'(div_by_zero), 32'(ez));
`else
        if (ez === 1'bx) $display("note: unexpected x flag in %s", name);
`endif
    endtask

    initial begin
        int n;

        vecs[0] = '{25'd120,      16'd10,    25'd12,       16'd0,   1'b0};
        vecs[1] = '{25'd100,      16'd7,     25'd14,       16'd2,   1'b0};
        vecs[2] = '{25'd33554431, 16'd65535, 25'd512,      16'd511, 1'b0};
        vecs[3] = '{25'd33554431, 16'd1,     25'd33554431, 16'd0,   1'b0};
        vecs[4] = '{25'd5,        16'd0,     25'h1FFFFFF,  16'd0,   1'b1};
        vecs[5] = '{25'd3,        16'd10,    25'd0,        16'd3,   1'b0};
        vecs[6] = '{25'd9,        16'd4,     25'd2,        16'd1,   1'b0};
        vecs[7] = '{25'd65535,    16'd65535, 25'd1,        16'd0,   1'b0};
        vecs[8] = '{25'd1000000,  16'd999,   25'd1001,     16'd1,   1'b0};

        sys_rst  = 1'b1;
        dividend = 25'd120;
        divisor  = 16'd10;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_rfd", 32'(rfd), 32'd1);
        chk("reset_quot", 32'(quotient), 32'd0);
        chk("reset_frac", 32'(fractional), 32'd0);
        sys_rst = 1'b0;

        // First division after reset, then the same operands again back to back.
        do_div("first_120_10", 25'd120, 16'd10, 25'd12, 16'd0, 1'b0);
        do_div("repeat_120_10", 25'd120, 16'd10, 25'd12, 16'd0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // Operand change while busy must not disturb the running division.
        dividend = 25'd120;
        divisor  = 16'd10;
        @(posedge sys_clk);
        #1;
        repeat (10) @(posedge sys_clk);
        #1;
        chk("midchg_busy", 32'(rfd), 32'd0);
        chk("midchg_hold_quot", 32'(quotient), 32'd1001);
        dividend = 25'd9;
        divisor  = 16'd4;
        wait_done("midchg_a", n);
        chk("midchg_a_latency", 32'(n + 11), 32'd26);
        chk("midchg_a_quot", 32'(quotient), 32'd12);
        chk("midchg_a_frac", 32'(fractional), 32'd0);
        @(posedge sys_clk);
        #1;
        wait_done("midchg_b", n);
        chk("midchg_b_quot", 32'(quotient), 32'd2);
        chk("midchg_b_frac", 32'(fractional), 32'd1);

        // Reset in the middle of a division aborts it.
        dividend = 25'd100;
        divisor  = 16'd7;
        @(posedge sys_clk);
        #1;
        repeat (5) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("midrst_rfd", 32'(rfd), 32'd1);
        chk("midrst_quot", 32'(quotient), 32'd0);
        chk("midrst_frac", 32'(fractional), 32'd0);
        do_div("after_rst", 25'd100, 16'd7, 25'd14, 16'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
